// File: rtl/tnet_tx_arbiter_if.sv
// tnet_tx_arbiter_if
// Bundles the requester side (req/hdr/dt/ack) and the Aurora TX AXI-stream
// side (tdata/tvalid/tlast/tready) of the TX arbiter.
//   req    : per-source packet request, level, held until ack
//   hdr    : per-source header word, slice i = [64*i +: 64]
//   dt     : per-source data word,   slice i = [64*i +: 64]
//   ack    : per-source one-hot ack (four-phase)
//   tdata  : TX beat data
//   tvalid : TX beat valid
//   tlast  : high on the data beat
//   tready : link ready
// master = arbiter side, slave = sources + link side.
interface tnet_tx_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*64-1:0] hdr;
  logic [NREQ*64-1:0] dt;
  logic [NREQ-1:0]    ack;
  logic [63:0]        tdata;
  logic               tvalid;
  logic               tlast;
  logic               tready;

  modport master (
    input  req, hdr, dt, tready,
    output ack, tdata, tvalid, tlast
  );

  modport slave (
    output req, hdr, dt, tready,
    input  ack, tdata, tvalid, tlast
  );
endinterface

// File: rtl/tnet_tx_arbiter.sv
// tnet_tx_arbiter
// Shares one Aurora TX AXI-stream link between NREQ packet sources. Each
// source offers a 2-beat packet (header, data); the winner is chosen with
// sync-flagged requests (hdr bit 55) first, then round-robin, and its beats
// are driven onto the link. Channel loss or a stall timeout aborts the packet.
// Ports:
//   user_clk_i    link user clock
//   user_rst_i    synchronous active-high reset
//   channel_ok_i  Aurora channel up
//   bus           requester handshake + TX stream (master modport)
//   grant_o       one-hot current owner, 0 when none
//   timeout_o     1-cycle pulse on stall timeout
//   pkt_cnt_o     packets fully sent, wraps
//
// state       | meaning
// NOT_READY   | channel down or just aborted, outputs idle
// IDLE        | waiting for a request, arbitrates
// LOAD        | latch winner's header/data, raise tvalid with header
// TX_H        | header beat on the link
// TX_D        | data beat on the link (tlast)
// WAIT_NREQ   | ack held until winner drops req
module tnet_tx_arbiter #(
  parameter int NREQ = 3,
  parameter int TO_W = 10
) (
  input  logic                user_clk_i,
  input  logic                user_rst_i,
  input  logic                channel_ok_i,
  tnet_tx_arbiter_if.master   bus,
  output logic [NREQ-1:0]     grant_o,
  output logic                timeout_o,
  output logic [7:0]          pkt_cnt_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Timeout fires on the stalled cycle that would take the counter to all-ones.
  localparam logic [TO_W-1:0] STALL_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_NOT_READY, S_IDLE, S_LOAD, S_TX_H, S_TX_D, S_WAIT_NREQ
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     win_q, win_d;
  // rr_q holds the first index searched, i.e. last winner + 1; reset 0 so
  // source 0 has priority after reset.
  logic [IW-1:0]     rr_q, rr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [63:0]       tdata_q, tdata_d;
  logic [63:0]       dt_q, dt_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        pkt_q, pkt_d;
  logic [TO_W-1:0]   stall_q, stall_d;

  logic [NREQ-1:0]   sync_req;
  logic [NREQ-1:0]   cand;
  logic              found;
  logic [IW-1:0]     pick;
  logic              stalled;
  int                idx;

  always_comb begin
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sync_req[i] = bus.req[i] & bus.hdr[64*i+55];
    end
    cand = (|sync_req) ? sync_req : bus.req;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    ack_d     = ack_q;
    tdata_d   = tdata_q;
    dt_d      = dt_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    timeout_d = 1'b0;
    pkt_d     = pkt_q;
    stall_d   = '0;

    stalled = tvalid_q & ~bus.tready & ((state_q == S_TX_H) || (state_q == S_TX_D));
    if (stalled) stall_d = stall_q + 1'b1;

    if (!channel_ok_i || (stalled && (stall_q == STALL_LAST))) begin
      // Abort: drop the packet uncounted; the source keeps req and is re-served.
      timeout_d = channel_ok_i;
      tvalid_d  = 1'b0;
      tlast_d   = 1'b0;
      grant_d   = '0;
      ack_d     = '0;
      stall_d   = '0;
      state_d   = S_NOT_READY;
    end else begin
      case (state_q)
        S_NOT_READY: state_d = S_IDLE;
        S_IDLE: begin
          if (found) begin
            win_d   = pick;
            grant_d = NREQ'(1) << pick;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          tdata_d  = bus.hdr[64*win_q +: 64];
          dt_d     = bus.dt[64*win_q +: 64];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = S_TX_H;
        end
        S_TX_H: begin
          if (bus.tready) begin
            tdata_d = dt_q;
            tlast_d = 1'b1;
            state_d = S_TX_D;
          end
        end
        S_TX_D: begin
          if (bus.tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            ack_d    = grant_q;
            pkt_d    = pkt_q + 8'd1;
            rr_d     = (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
            state_d  = S_WAIT_NREQ;
          end
        end
        S_WAIT_NREQ: begin
          if (!bus.req[win_q]) begin
            ack_d   = '0;
            grant_d = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_NOT_READY;
      endcase
    end
  end

  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      state_q   <= S_NOT_READY;
      win_q     <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      tdata_q   <= '0;
      dt_q      <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      timeout_q <= 1'b0;
      pkt_q     <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tdata_q   <= tdata_d;
      dt_q      <= dt_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      timeout_q <= timeout_d;
      pkt_q     <= pkt_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.tdata  = tdata_q;
  assign bus.tvalid = tvalid_q;
  assign bus.tlast  = tlast_q;
  assign grant_o    = grant_q;
  assign timeout_o  = timeout_q;
  assign pkt_cnt_o  = pkt_q;

endmodule

// File: tb/tb_tnet_tx_arbiter.sv
// tb_tnet_tx_arbiter
// Directed stimulus for tnet_tx_arbiter (NREQ=3, TO_W=4). Expected beats and
// grants are queued as stimulus is issued; a monitor compares them against the
// link and grant_o as they appear.
module tb_tnet_tx_arbiter;
  localparam int NREQ = 3;
  localparam int TO_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            ch_ok;
  logic [NREQ-1:0] grant;
  logic            timeout;
  logic [7:0]      pkt_cnt;

  tnet_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  tnet_tx_arbiter #(.NREQ(NREQ), .TO_W(TO_W)) dut (
    .user_clk_i   (clk),
    .user_rst_i   (rst),
    .channel_ok_i (ch_ok),
    .bus          (bus),
    .grant_o      (grant),
    .timeout_o    (timeout),
    .pkt_cnt_o    (pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_to  = 0;
  int exp_pkt = 0;

  logic [64:0]     beat_q[$];   // {tlast, tdata}
  logic [NREQ-1:0] grant_q[$];
  logic [NREQ-1:0] grant_prev = '0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares accepted beats and each new grant against the queues.
  initial begin
    logic [64:0] eb;
    logic [NREQ-1:0] eg;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (timeout) n_to++;
        if (bus.tvalid && bus.tready) begin
          if (beat_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL beat: unexpected beat %0h tlast %b", bus.tdata, bus.tlast);
          end else begin
            eb = beat_q.pop_front();
            check("beat", {bus.tlast, bus.tdata}, eb);
          end
        end
        if (grant != '0 && grant_prev == '0) begin
          if (grant_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL grant: unexpected grant %b", grant);
          end else begin
            eg = grant_q.pop_front();
            check("grant", 65'(grant), 65'(eg));
          end
        end
      end
      grant_prev = grant;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [63:0] h, input logic [63:0] d);
    bus.hdr[64*i +: 64] = h;
    bus.dt[64*i +: 64]  = d;
  endtask

  task automatic expect_pkt(input int i, input logic [63:0] h, input logic [63:0] d);
    beat_q.push_back({1'b0, h});
    beat_q.push_back({1'b1, d});
    grant_q.push_back(NREQ'(1) << i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    cyc(2);
    rst = 1'b0;
    exp_pkt = 0;
    cyc(2);
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      if (bus.tvalid) break;
      cyc(1);
    end
    n_vec++;
    if (!bus.tvalid) begin
      n_err++;
      $display("FAIL %s: tvalid never rose within 20 cycles", name);
    end
  endtask

  // Wait for ack of src, check it is one-hot, then drop req (four-phase).
  task automatic wait_ack_drop(input int src);
    int k;
    for (k = 0; k < 60; k++) begin
      if (bus.ack[src]) break;
      cyc(1);
    end
    if (!bus.ack[src]) begin
      n_vec++; n_err++;
      $display("FAIL ack_wait: src %0d ack=%b, expected bit set within 60 cycles", src, bus.ack);
    end else begin
      exp_pkt++;
      check("ack_onehot", 65'(bus.ack), 65'(NREQ'(1) << src));
      check("pkt_cnt", 65'(pkt_cnt), 65'(exp_pkt[7:0]));
    end
    bus.req[src] = 1'b0;
    cyc(2);
    check("ack_released", 65'(bus.ack), 65'(0));
  endtask

  initial begin
    rst = 1'b1;
    ch_ok = 1'b0;
    bus.req = '0;
    bus.hdr = '0;
    bus.dt = '0;
    bus.tready = 1'b0;
    cyc(3);
    check("rst_grant",   65'(grant), 65'(0));
    check("rst_tvalid",  65'(bus.tvalid), 65'(0));
    check("rst_tlast",   65'(bus.tlast), 65'(0));
    check("rst_tdata",   65'(bus.tdata), 65'(0));
    check("rst_ack",     65'(bus.ack), 65'(0));
    check("rst_timeout", 65'(timeout), 65'(0));
    check("rst_pkt",     65'(pkt_cnt), 65'(0));
    ch_ok = 1'b1;
    bus.tready = 1'b1;
    rst = 1'b0;
    cyc(2);

    // 1: single request, latency and back-to-back beats
    set_src(1, 64'hA, 64'hB);
    expect_pkt(1, 64'hA, 64'hB);
    bus.req = 3'b010;
    cyc(1);
    check("t1_lat_c1_tvalid", 65'(bus.tvalid), 65'(0));
    cyc(1);
    check("t1_lat_c2_tvalid", 65'(bus.tvalid), 65'(1));
    check("t1_hdr", {bus.tlast, bus.tdata}, {1'b0, 64'hA});
    cyc(1);
    check("t1_data", {bus.tlast, bus.tdata}, {1'b1, 64'hB});
    wait_ack_drop(1);
    check("t1_grant_clr", 65'(grant), 65'(0));

    // 2: three plain requests, round-robin 0,1,2 twice
    do_reset();
    for (int i = 0; i < NREQ; i++) set_src(i, 64'h1000 + 64'(i), 64'h2000 + 64'(i));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) expect_pkt(i, 64'h1000 + 64'(i), 64'h2000 + 64'(i));
      bus.req = 3'b111;
      for (int i = 0; i < NREQ; i++) wait_ack_drop(i);
      check("t2_pkt_round", 65'(pkt_cnt), 65'(3 * (r + 1)));
    end

    // 3: sync flag on source 1 beats rr pointer at 0
    do_reset();
    set_src(0, 64'h30, 64'h40);
    set_src(1, 64'h0080_0000_0000_0031, 64'h41);
    expect_pkt(1, 64'h0080_0000_0000_0031, 64'h41);
    expect_pkt(0, 64'h30, 64'h40);
    bus.req = 3'b011;
    wait_ack_drop(1);
    wait_ack_drop(0);

    // 4: header stalled 5 cycles
    set_src(2, 64'hC0FFEE, 64'hD00D);
    expect_pkt(2, 64'hC0FFEE, 64'hD00D);
    bus.tready = 1'b0;
    bus.req = 3'b100;
    wait_valid("t4_valid");
    for (int k = 0; k < 5; k++) begin
      check("t4_hold", {bus.tvalid, bus.tlast, bus.tdata[62:0]}, {1'b1, 1'b0, 63'hC0FFEE});
      cyc(1);
    end
    bus.tready = 1'b1;
    wait_ack_drop(2);
    check("t4_no_timeout", 65'(n_to), 65'(0));

    // 5: stall timeout (TO_W=4), then resend
    begin
      int stalls;
      set_src(0, 64'h5A5A, 64'h6B6B);
      grant_q.push_back(3'b001);
      expect_pkt(0, 64'h5A5A, 64'h6B6B);
      bus.tready = 1'b0;
      bus.req = 3'b001;
      wait_valid("t5_valid");
      stalls = 0;
      for (int k = 0; k < 40; k++) begin
        if (timeout) break;
        if (bus.tvalid && !bus.tready) stalls++;
        cyc(1);
      end
      check("t5_timeout_seen", 65'(timeout), 65'(1));
      check("t5_stall_cycles", 65'(stalls), 65'(15));
      check("t5_tvalid_off", 65'(bus.tvalid), 65'(0));
      check("t5_grant_off", 65'(grant), 65'(0));
      check("t5_no_ack", 65'(bus.ack), 65'(0));
      check("t5_pkt_same", 65'(pkt_cnt), 65'(exp_pkt[7:0]));
      bus.tready = 1'b1;
      wait_ack_drop(0);
      check("t5_one_timeout", 65'(n_to), 65'(1));
    end

    // 6: channel drop during data beat, then recovery
    set_src(1, 64'h7777, 64'h8888);
    grant_q.push_back(3'b010);
    beat_q.push_back({1'b0, 64'h7777});
    expect_pkt(1, 64'h7777, 64'h8888);
    bus.tready = 1'b0;
    bus.req = 3'b010;
    wait_valid("t6_valid");
    bus.tready = 1'b1;
    cyc(1);
    bus.tready = 1'b0;
    check("t6_in_data", {bus.tlast, bus.tdata}, {1'b1, 64'h8888});
    ch_ok = 1'b0;
    cyc(1);
    check("t6_tvalid_off", 65'(bus.tvalid), 65'(0));
    check("t6_grant_off", 65'(grant), 65'(0));
    check("t6_pkt_same", 65'(pkt_cnt), 65'(exp_pkt[7:0]));
    cyc(3);
    ch_ok = 1'b1;
    bus.tready = 1'b1;
    wait_ack_drop(1);

    cyc(3);
    check("beat_q_empty", 65'(beat_q.size()), 65'(0));
    check("grant_q_empty", 65'(grant_q.size()), 65'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
